mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 19 +
 rtl/mem_bus_arbiter_if.sv | 41 ++++
 rtl/mem_arb_grant.sv | 41 ++++
 rtl/mem_bus_arbiter.sv | 99 +++++++++
 tb/tb_mem_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int BIT_WIDTH = 32;

    typedef logic [1:0] size_t;

    localparam size_t SZ_WORD = 2'b00;
    localparam size_t SZ_HALF = 2'b01;
    localparam size_t SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        I_BUSY = 2'b01,
        D_BUSY = 2'b10,
        ACK    = 2'b11
    } state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_bus_arbiter_if #(
    parameter int BIT_WIDTH = mem_bus_arbiter_pkg::BIT_WIDTH
);
    import mem_bus_arbiter_pkg::*;

    logic                 I_REQ;
    logic [BIT_WIDTH-1:0] IAD;
    logic [BIT_WIDTH-1:0] IDT;
    logic                 ACKI_n;

    logic                 MREQ;
    logic                 WRITE;
    size_t                SIZE;
    logic [BIT_WIDTH-1:0] DAD;
    logic [BIT_WIDTH-1:0] D_WDT;
    logic [BIT_WIDTH-1:0] D_RDT;
    logic                 ACKD_n;

    logic                 M_MREQ;
    logic                 M_WRITE;
    size_t                M_SIZE;
    logic [BIT_WIDTH-1:0] M_AD;
    logic [BIT_WIDTH-1:0] M_WDT;
    logic [BIT_WIDTH-1:0] M_RDT;
    logic                 M_ACK_n;

    modport slave (
        input  I_REQ, IAD, MREQ, WRITE, SIZE, DAD, D_WDT, M_RDT, M_ACK_n,
        output IDT, ACKI_n, D_RDT, ACKD_n,
               M_MREQ, M_WRITE, M_SIZE, M_AD, M_WDT
    );

    modport master (
        output I_REQ, IAD, MREQ, WRITE, SIZE, DAD, D_WDT, M_RDT, M_ACK_n,
        input  IDT, ACKI_n, D_RDT, ACKD_n,
               M_MREQ, M_WRITE, M_SIZE, M_AD, M_WDT
    );

endinterface

// File: rtl/mem_arb_grant.sv
// Grant decision between fetch and data requests, with a starvation guard
// that hands the bus to a waiting fetch after DSTARVE_MAX data grants.
module mem_arb_grant #(
    parameter int DSTARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic i_req,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);
    import mem_bus_arbiter_pkg::*;

    localparam int STREAK_W = $clog2(DSTARVE_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DSTARVE_MAX);

    logic [STREAK_W-1:0] d_streak;
    logic                starve;

    assign starve  = i_req && (d_streak == STREAK_MAX);
    assign grant_d = idle && d_req && !starve;
    assign grant_i = idle && i_req && !grant_d;

    // Count back-to-back data grants that happened while a fetch was waiting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            d_streak <= '0;
        end else if (grant_d) begin
            if (!i_req) begin
                d_streak <= '0;
            end else if (d_streak != STREAK_MAX) begin
                d_streak <= d_streak + STREAK_W'(1);
            end
        end else if (grant_i) begin
            d_streak <= '0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a fetch port and a data port onto one unified memory bus.
// Each transaction runs IDLE -> BUSY (until memory acks) -> ACK -> IDLE.
module mem_bus_arbiter #(
    parameter int BIT_WIDTH   = mem_bus_arbiter_pkg::BIT_WIDTH,
    parameter int DSTARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.slave   bus
);
    import mem_bus_arbiter_pkg::*;

    localparam logic [BIT_WIDTH-1:0] ZERO_WORD = '0;

    state_t state;
    logic   in_idle;
    logic   grant_i;
    logic   grant_d;

    assign in_idle = (state == IDLE);

    mem_arb_grant #(
        .DSTARVE_MAX (DSTARVE_MAX)
    ) u_grant (
        .clk     (clk),
        .rst     (rst),
        .idle    (in_idle),
        .i_req   (bus.I_REQ),
        .d_req   (bus.MREQ),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    // Transaction FSM; every bus-facing output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            bus.M_MREQ  <= 1'b0;
            bus.M_WRITE <= 1'b0;
            bus.M_SIZE  <= SZ_WORD;
            bus.M_AD    <= ZERO_WORD;
            bus.M_WDT   <= ZERO_WORD;
            bus.ACKI_n  <= 1'b1;
            bus.ACKD_n  <= 1'b1;
            bus.IDT     <= ZERO_WORD;
            bus.D_RDT   <= ZERO_WORD;
        end else begin
            case (state)
                IDLE: begin
                    bus.ACKI_n <= 1'b1;
                    bus.ACKD_n <= 1'b1;
                    if (grant_d) begin
                        state       <= D_BUSY;
                        bus.M_MREQ  <= 1'b1;
                        bus.M_WRITE <= bus.WRITE;
                        bus.M_SIZE  <= bus.SIZE;
                        bus.M_AD    <= bus.DAD;
                        bus.M_WDT   <= bus.WRITE ? bus.D_WDT : ZERO_WORD;
                    end else if (grant_i) begin
                        state       <= I_BUSY;
                        bus.M_MREQ  <= 1'b1;
                        bus.M_WRITE <= 1'b0;
                        bus.M_SIZE  <= SZ_WORD;
                        bus.M_AD    <= bus.IAD;
                        bus.M_WDT   <= ZERO_WORD;
                    end
                end
                I_BUSY: begin
                    if (!bus.M_ACK_n) begin
                        state      <= ACK;
                        bus.M_MREQ <= 1'b0;
                        bus.IDT    <= bus.M_RDT;
                        bus.ACKI_n <= 1'b0;
                    end
                end
                D_BUSY: begin
                    if (!bus.M_ACK_n) begin
                        state      <= ACK;
                        bus.M_MREQ <= 1'b0;
                        bus.ACKD_n <= 1'b0;
                        if (!bus.M_WRITE) begin
                            bus.D_RDT <= bus.M_RDT;
                        end
                    end
                end
                ACK: begin
                    state      <= IDLE;
                    bus.M_MREQ <= 1'b0;
                    bus.ACKI_n <= 1'b1;
                    bus.ACKD_n <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter with a simple memory model.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    int          mem_lat       = 1;
    logic [31:0] mem_rdata     = '0;
    logic        mem_force_ack = 1'b0;
    int          busy_cnt      = 0;

    int     acki_cnt = 0;
    int     ackd_cnt = 0;
    bit     grant_log[$];
    state_t prev_state = IDLE;

    mem_bus_arbiter_if #(.BIT_WIDTH(32)) bus ();

    mem_bus_arbiter #(
        .BIT_WIDTH   (32),
        .DSTARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: acks in the mem_lat-th cycle of M_MREQ being high
    initial begin
        bus.M_ACK_n = 1'b1;
        bus.M_RDT   = '0;
        forever begin
            @(negedge clk);
            if (bus.M_MREQ) busy_cnt++;
            else            busy_cnt = 0;
            bus.M_RDT   = mem_rdata;
            bus.M_ACK_n = !(mem_force_ack || (bus.M_MREQ && busy_cnt == mem_lat));
        end
    end

    // Monitor: count ack-low cycles and log each grant (1 = data, 0 = fetch)
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.ACKI_n === 1'b0) acki_cnt++;
            if (bus.ACKD_n === 1'b0) ackd_cnt++;
            if (prev_state == IDLE && dut.state == D_BUSY) grant_log.push_back(1'b1);
            if (prev_state == IDLE && dut.state == I_BUSY) grant_log.push_back(1'b0);
            prev_state = dut.state;
        end
    end

    // Global time limit
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic i_req, input logic [31:0] iad,
                                 input logic mreq, input logic write,
                                 input logic [1:0] size, input logic [31:0] dad,
                                 input logic [31:0] wdt);
        bus.I_REQ = i_req;
        bus.IAD   = iad;
        bus.MREQ  = mreq;
        bus.WRITE = write;
        bus.SIZE  = size;
        bus.DAD   = dad;
        bus.D_WDT = wdt;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic waitAckI(input string tag, input int budget);
        int n = 0;
        while (bus.ACKI_n !== 1'b0 && n < budget) begin
            step(1);
            n++;
        end
        checkOutput(tag, 32'(bus.ACKI_n), 32'd0);
    endtask

    initial begin
        int          n;
        int          acki_base;
        int          ackd_base;
        logic [4:0]  pattern;

        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);

        // Reset state
        step(2);
        checkOutput("rst_state",  32'(dut.state), 32'(IDLE));
        checkOutput("rst_mreq",   32'(bus.M_MREQ), 32'd0);
        checkOutput("rst_acki",   32'(bus.ACKI_n), 32'd1);
        checkOutput("rst_ackd",   32'(bus.ACKD_n), 32'd1);
        checkOutput("rst_idt",    bus.IDT, 32'h0);
        checkOutput("rst_drdt",   bus.D_RDT, 32'h0);
        checkOutput("rst_mad",    bus.M_AD, 32'h0);
        rst = 1'b1;
        step(1);

        // Fetch only, memory acks in first BUSY cycle
        $display("[TB] fetch only");
        mem_lat   = 1;
        mem_rdata = 32'h0000_0013;
        applyStimulus(1'b1, 32'h0000_0004, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        step(1);
        checkOutput("f_mreq",  32'(bus.M_MREQ), 32'd1);
        checkOutput("f_mad",   bus.M_AD, 32'h0000_0004);
        checkOutput("f_mwr",   32'(bus.M_WRITE), 32'd0);
        step(1);
        checkOutput("f_acki",  32'(bus.ACKI_n), 32'd0);
        checkOutput("f_ackd",  32'(bus.ACKD_n), 32'd1);
        checkOutput("f_idt",   bus.IDT, 32'h0000_0013);
        checkOutput("f_ackmreq", 32'(bus.M_MREQ), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        step(1);
        checkOutput("f_acki_end", 32'(bus.ACKI_n), 32'd1);
        checkOutput("f_idt_hold", bus.IDT, 32'h0000_0013);

        // Simultaneous fetch and load: data first, fetch next
        $display("[TB] simultaneous requests");
        mem_rdata = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b0, SZ_WORD, 32'h8000_0000, 32'h0);
        step(1);
        checkOutput("s_state1", 32'(dut.state), 32'(D_BUSY));
        checkOutput("s_mad1",   bus.M_AD, 32'h8000_0000);
        mem_rdata = 32'h0000_AAAA;
        step(1);
        checkOutput("s_ackd",   32'(bus.ACKD_n), 32'd0);
        checkOutput("s_acki",   32'(bus.ACKI_n), 32'd1);
        checkOutput("s_drdt",   bus.D_RDT, 32'hDEAD_BEEF);
        bus.MREQ = 1'b0;
        step(1);
        checkOutput("s_idle",   32'(dut.state), 32'(IDLE));
        step(1);
        checkOutput("s_state2", 32'(dut.state), 32'(I_BUSY));
        checkOutput("s_mad2",   bus.M_AD, 32'h0000_0100);
        step(1);
        checkOutput("s_acki2",  32'(bus.ACKI_n), 32'd0);
        checkOutput("s_idt",    bus.IDT, 32'h0000_AAAA);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        step(1);

        // Starvation guard: four data grants then the waiting fetch
        $display("[TB] starvation");
        grant_log.delete();
        mem_rdata = 32'h0000_0777;
        applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b0, SZ_WORD, 32'h8000_0010, 32'h0);
        n = 0;
        while (grant_log.size() < 5 && n < 40) begin
            step(1);
            n++;
        end
        checkOutput("st_count", 32'(grant_log.size()), 32'd5);
        pattern = '0;
        for (int i = 0; i < 5 && i < grant_log.size(); i++) pattern = {pattern[3:0], grant_log[i]};
        checkOutput("st_order",  32'(pattern), 32'b11110);
        checkOutput("st_state",  32'(dut.state), 32'(I_BUSY));
        checkOutput("st_streak", 32'(dut.u_grant.d_streak), 32'd0);
        waitAckI("st_acki", 10);
        checkOutput("st_idt", bus.IDT, 32'h0000_0777);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        step(1);

        // Wait states: three BUSY cycles, half-word load
        $display("[TB] wait states");
        mem_lat   = 3;
        mem_rdata = 32'h1234_5678;
        ackd_base = ackd_cnt;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, SZ_HALF, 32'h8000_0020, 32'h0000_0055);
        for (int i = 0; i < 3; i++) begin
            step(1);
            checkOutput("w_state", 32'(dut.state), 32'(D_BUSY));
            checkOutput("w_mad",   bus.M_AD, 32'h8000_0020);
            checkOutput("w_msize", 32'(bus.M_SIZE), 32'(SZ_HALF));
            checkOutput("w_ackd",  32'(bus.ACKD_n), 32'd1);
        end
        checkOutput("w_mwdt", bus.M_WDT, 32'h0);
        step(1);
        checkOutput("w_ackd_lo", 32'(bus.ACKD_n), 32'd0);
        checkOutput("w_drdt",    bus.D_RDT, 32'h1234_5678);
        bus.MREQ = 1'b0;
        step(1);
        checkOutput("w_ackd_hi", 32'(bus.ACKD_n), 32'd1);
        checkOutput("w_pulses",  32'(ackd_cnt - ackd_base), 32'd1);

        // Byte store leaves D_RDT untouched
        $display("[TB] byte store");
        mem_lat   = 1;
        mem_rdata = 32'hFFFF_FFFF;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, SZ_BYTE, 32'h8000_0003, 32'h0000_00AB);
        step(1);
        checkOutput("b_mwr",   32'(bus.M_WRITE), 32'd1);
        checkOutput("b_msize", 32'(bus.M_SIZE), 32'(SZ_BYTE));
        checkOutput("b_mwdt",  bus.M_WDT, 32'h0000_00AB);
        checkOutput("b_mad",   bus.M_AD, 32'h8000_0003);
        step(1);
        checkOutput("b_ackd",  32'(bus.ACKD_n), 32'd0);
        checkOutput("b_drdt",  bus.D_RDT, 32'h1234_5678);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        step(1);

        // Fetch after a store must clear the write-side fields
        $display("[TB] fetch after store");
        mem_rdata = 32'h0000_0093;
        applyStimulus(1'b1, 32'h0000_0008, 1'b0, 1'b1, SZ_BYTE, 32'h0, 32'h0000_00CD);
        step(1);
        checkOutput("fs_mwr",   32'(bus.M_WRITE), 32'd0);
        checkOutput("fs_msize", 32'(bus.M_SIZE), 32'(SZ_WORD));
        checkOutput("fs_mwdt",  bus.M_WDT, 32'h0);
        checkOutput("fs_mad",   bus.M_AD, 32'h0000_0008);
        step(1);
        checkOutput("fs_idt",   bus.IDT, 32'h0000_0093);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        step(1);

        // Reset while in D_BUSY abandons the transaction
        $display("[TB] reset in D_BUSY");
        mem_lat = 100;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, SZ_WORD, 32'h8000_0040, 32'h0);
        step(1);
        checkOutput("r_busy", 32'(dut.state), 32'(D_BUSY));
        acki_base = acki_cnt;
        ackd_base = ackd_cnt;
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
        step(1);
        rst = 1'b1;
        checkOutput("r_state", 32'(dut.state), 32'(IDLE));
        checkOutput("r_mreq",  32'(bus.M_MREQ), 32'd0);
        checkOutput("r_acki",  32'(bus.ACKI_n), 32'd1);
        checkOutput("r_ackd",  32'(bus.ACKD_n), 32'd1);
        checkOutput("r_idt",   bus.IDT, 32'h0);
        step(5);
        checkOutput("r_no_acki", 32'(acki_cnt - acki_base), 32'd0);
        checkOutput("r_no_ackd", 32'(ackd_cnt - ackd_base), 32'd0);

        // Stray memory ack while idle is ignored
        $display("[TB] stray ack in IDLE");
        mem_force_ack = 1'b1;
        step(4);
        mem_force_ack = 1'b0;
        step(1);
        checkOutput("x_state", 32'(dut.state), 32'(IDLE));
        checkOutput("x_acks",  32'((acki_cnt - acki_base) + (ackd_cnt - ackd_base)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
